// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (FSM state encoding, frame sizes and the
// parity helper). Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    RECV_BITS = 2'd2,
    STOP      = 2'd3
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 9;  // data + parity

  // Parity bit carried on the wire: XOR of the data byte.
  function automatic logic parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the asynchronous RX pin plus a
// falling-edge detector on the synchronized line.
//   clock  in  system clock
//   reset  in  synchronous, active-high reset (all flops cleared to 0)
//   i_rx   in  asynchronous serial line
//   rx_s   out synchronized line (2 cycles after the pin)
//   fall   out high for one cycle when rx_s goes 1 -> 0
// Everything resets to 0, so a line held low through reset never produces
// a fall: a 1 has to be observed first.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= i_rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start / 8 data (LSB first) / 1 even-XOR parity /
// 1 stop. Samples at mid-bit and reports each frame with one-cycle pulses.
//   clock         in  system clock
//   reset         in  synchronous, active-high reset
//   i_rx          in  asynchronous serial line, idle high
//   o_data_byte   out last good-stop byte (held across framing errors)
//   o_data_valid  out 1-cycle pulse, o_data_byte updated
//   o_parity_err  out 1-cycle pulse alongside o_data_valid on parity mismatch
//   o_frame_err   out 1-cycle pulse, stop bit sampled 0
//   o_active      out high from start detection until the frame ends
// Optional build macro UART_RX_MAJORITY_EN: each sample is the 2-of-3 vote
// of rx_s around the nominal point, decided one cycle later
// (needs clk_per_bit >= 8).
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_per_bit = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_data_byte,
  output logic       o_data_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_active
);

  localparam logic [15:0] HALF = 16'((clk_per_bit - 1) / 2);
  localparam logic [15:0] LAST = 16'(clk_per_bit - 1);

  logic rx_s, fall, bit_smp;

  uart_rx_sync u_sync (
    .clock (clock),
    .reset (reset),
    .i_rx  (i_rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // Decision moves to target+1; reloading the counter with 1 instead of 0
  // keeps successive decisions exactly clk_per_bit apart.
  localparam logic [15:0] START_TGT = HALF + 16'd1;
  localparam logic [15:0] BIT_TGT   = LAST + 16'd1;
  localparam logic [15:0] RELOAD    = 16'd1;

  logic [1:0] hist_q;  // [1] = rx_s two cycles ago, [0] = one cycle ago

  always_ff @(posedge clock) begin
    if (reset) hist_q <= 2'b00;
    else       hist_q <= {hist_q[0], rx_s};
  end

  assign bit_smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  localparam logic [15:0] START_TGT = HALF;
  localparam logic [15:0] BIT_TGT   = LAST;
  localparam logic [15:0] RELOAD    = 16'd0;

  assign bit_smp = rx_s;
`endif

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [8:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        active_q, active_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    active_d = active_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        if (fall) begin
          // The edge cycle itself is count 0, so start counting at 1.
          cnt_d    = 16'd1;
          active_d = 1'b1;
          state_d  = START;
        end
      end

      START: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == START_TGT) begin
          if (!bit_smp) begin
            cnt_d   = RELOAD;
            idx_d   = '0;
            state_d = RECV_BITS;
          end else begin
            // Line back high at mid-start: glitch, drop it silently.
            cnt_d    = '0;
            active_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end

      RECV_BITS: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == BIT_TGT) begin
          cnt_d          = RELOAD;
          shift_d[idx_q] = bit_smp;
          if (idx_q == 4'(FRAME_BITS - 1)) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      STOP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == BIT_TGT) begin
          if (bit_smp) begin
            byte_d  = shift_q[7:0];
            valid_d = 1'b1;
            perr_d  = shift_q[8] != parity(shift_q[7:0]);
          end else begin
            ferr_d = 1'b1;
          end
          // Leave at mid-stop so a back-to-back start edge is not missed.
          cnt_d    = '0;
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        byte_d   = '0;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_data_byte  = byte_q;
  assign o_data_valid = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_active     = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized + directed bench for uart_rx at clk_per_bit=16.
// A line driver serializes frames bit by bit; every frame it sends pushes its
// expected outcome (byte, error flags, arrival cycle) into a queue, and a
// monitor matches every output pulse against that queue.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = HALF + 10 * CPB + 3 + 1;
`else
  // pin low -> detected edge takes 3 edges, then HALF+10 bits to the stop
  // sample and one more cycle for the registered outputs.
  localparam int LAT = HALF + 10 * CPB + 3;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       i_rx;
  logic [7:0] o_data_byte;
  logic       o_data_valid, o_parity_err, o_frame_err, o_active;

  uart_rx #(.clk_per_bit(CPB)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_rx         (i_rx),
    .o_data_byte  (o_data_byte),
    .o_data_valid (o_data_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_active     (o_active)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         perr;
    bit         ferr;
    int         t;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] last_good = 8'h00;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) @cyc %0d", tag, got, got, want, want, cyc);
    end
  endtask

  // Serialize one frame starting at the current negedge.
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stopv);
    logic [10:0] bits;
    exp_t e;
    bits = {stopv, (^d) ^ flip, d, 1'b0};
    e.data = d;
    e.ferr = !stopv;
    e.perr = stopv && flip;
    e.t    = cyc + LAT;
    expq.push_back(e);
    for (int b = 0; b < 11; b++) begin
      i_rx = bits[b];
      repeat (CPB) @(negedge clock);
    end
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every pulse must match the next expected frame.
  always @(negedge clock) begin
    if (!reset && (o_data_valid || o_parity_err || o_frame_err)) begin
      chk("excl", int'(o_data_valid & o_frame_err), 0);
      if (expq.size() == 0) begin
        chk("spurious", int'({o_data_valid, o_parity_err, o_frame_err}), 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("when", cyc, e.t);
        chk("valid", int'(o_data_valid), int'(!e.ferr));
        chk("ferr", int'(o_frame_err), int'(e.ferr));
        chk("perr", int'(o_parity_err), int'(e.perr));
        if (!e.ferr) begin
          chk("byte", int'(o_data_byte), int'(e.data));
          last_good = e.data;
        end else begin
          chk("hold", int'(o_data_byte), int'(last_good));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    i_rx  = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_byte", int'(o_data_byte), 0);
    chk("rst_valid", int'(o_data_valid), 0);
    chk("rst_perr", int'(o_parity_err), 0);
    chk("rst_ferr", int'(o_frame_err), 0);
    chk("rst_active", int'(o_active), 0);
    reset = 1'b0;
    idle(8);

    // Good frame, latency checked by the monitor.
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(20);
    // Wrong parity bit.
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);

    // Framing error followed by a 40-bit break.
    send_frame(8'h3C, 1'b0, 1'b0);
    i_rx = 1'b0;
    repeat (20 * CPB) @(negedge clock);
    chk("break_active", int'(o_active), 0);
    repeat (20 * CPB) @(negedge clock);
    chk("break_active2", int'(o_active), 0);
    chk("break_pending", expq.size(), 0);
    idle(2 * CPB);
    send_frame(8'hC3, 1'b0, 1'b1);
    idle(10);

    // Short glitch: start aborted, no pulses.
    i_rx = 1'b0;
    repeat (4) @(negedge clock);
    i_rx = 1'b1;
    chk("glitch_active_hi", int'(o_active), 1);
    repeat (10) @(negedge clock);
    chk("glitch_active_lo", int'(o_active), 0);
    idle(CPB);

    // Back-to-back frames, no idle between stop and next start.
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'h80, 1'b0, 1'b1);
    idle(2 * CPB);

    // Reset in the middle of data bit 4 of 0x5A; the frame is abandoned.
    begin
      logic [7:0] d;
      d = 8'h5A;
      i_rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int b = 0; b < 4; b++) begin
        i_rx = d[b];
        repeat (CPB) @(negedge clock);
      end
      i_rx = d[4];
      repeat (CPB / 2) @(negedge clock);
      chk("pre_rst_active", int'(o_active), 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      last_good = 8'h00;
      chk("mid_rst_byte", int'(o_data_byte), 0);
      chk("mid_rst_active", int'(o_active), 0);
      chk("mid_rst_pulses", int'({o_data_valid, o_parity_err, o_frame_err}), 0);
      idle(12 * CPB);
    end
    send_frame(8'h81, 1'b0, 1'b1);
    idle(20);

    // Random frames with random gaps, parity and stop faults.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      bit flip, stopv;
      int gap;
      d     = 8'($urandom);
      flip  = ($urandom % 4) == 0;
      stopv = ($urandom % 5) != 0;
      send_frame(d, flip, stopv);
      gap = $urandom_range(0, 20);
      if (!stopv && gap < 4) gap = 4;
      if (gap > 0) idle(gap);
    end

    idle(3 * CPB);
    chk("pending", expq.size(), 0);
    chk("final_active", int'(o_active), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
